// File: rtl/hwsw_pkg.sv
// hwsw_pkg: shared types and constants for the CPU-to-hardware object table
// handshake (hwsw_frame_commit and its per-slot storage).
package hwsw_pkg;

   localparam int COORD_W = 10;

   // CPU phase code carried on to_hw_sig / echoed on to_sw_sig
   typedef enum logic [1:0] {
      IDLE_P = 2'd0,
      X_P    = 2'd1,
      Y_P    = 2'd2,
      ST_P   = 2'd3
   } hwsw_phase_e;

   // Handshake controller states
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_ACK     = 2'd2
   } hwsw_fsm_e;

   // One object record; "type" is a reserved word, hence typ
   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [2:0]         state;
      logic [2:0]         typ;
   } obj_rec_t;

   // seen_mask bit for a phase: bit index is the phase code, with ST (3)
   // folded onto bit 0 so that the three phases fill a 3-bit mask.
   function automatic logic [2:0] phase_bit(input hwsw_phase_e ph);
      logic [2:0] b;
      b = 3'b000;
      case (ph)
         X_P:     b = 3'b010;
         Y_P:     b = 3'b100;
         ST_P:    b = 3'b001;
         default: b = 3'b000;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/hwsw_obj_slot.sv
// hwsw_obj_slot: one object slot. Holds the shadow record written by the
// handshake controller and the active record the renderers read. The active
// record only changes on a commit strobe, which copies the whole shadow.
// Optional feature: HWSW_YFLIP_EN makes slots other than 0 store
// SCREEN_H - y (10-bit wrap) instead of the raw Y coordinate.
module hwsw_obj_slot
   import hwsw_pkg::*;
#(
   parameter int SLOT_IDX = 0,
   parameter int SCREEN_H = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  hwsw_phase_e wr_phase,   // IDLE_P = no write this cycle
   input  logic [31:0] wr_data,
   input  logic        commit,
   output obj_rec_t    active
);

`ifdef HWSW_YFLIP_EN
   localparam bit YFLIP = 1'b1;
`else
   localparam bit YFLIP = 1'b0;
`endif

   localparam logic [COORD_W-1:0] SCREEN_H_C = COORD_W'(SCREEN_H);

   obj_rec_t           shadow_q, shadow_d;
   obj_rec_t           active_q, active_d;
   logic [COORD_W-1:0] y_in;

   // Only the low word bits carry fields; the rest of the CPU port is ignored
   logic unused_data_hi;
   assign unused_data_hi = ^wr_data[31:COORD_W];

   // Next shadow/active values: phase-selected field write, bank copy on commit
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      y_in     = wr_data[COORD_W-1:0];
      shadow_d = shadow_q;
      active_d = active_q;

      // Slot 0 is the player cursor and is never flipped
      if (YFLIP && (SLOT_IDX != 0)) begin
         y_in = SCREEN_H_C - wr_data[COORD_W-1:0];
      end

      case (wr_phase)
         X_P:  shadow_d.x = wr_data[COORD_W-1:0];
         Y_P:  shadow_d.y = y_in;
         ST_P: begin
            shadow_d.state = wr_data[2:0];
            shadow_d.typ   = wr_data[5:3];
         end
         default: ;
      endcase

      // Active takes the shadow from before any same-cycle capture
      if (commit) begin
         active_d = shadow_q;
      end
   end

   // Shadow and active records
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: both banks are reset because the renderers must see zeros until the first commit.
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values.
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign active = active_q;

endmodule

// File: rtl/hwsw_frame_commit.sv
// hwsw_frame_commit: registered four-phase handshake between the CPU PIO
// ports and the object table. Each phase (X, Y, STATE/TYPE) is captured for
// all slots into a shadow bank; the shadow is copied to the active bank only
// on frame_start once all three phases have been seen, so renderers never
// see fields from different CPU updates.
// Optional feature: HWSW_YFLIP_EN (Y stored as SCREEN_H - y for slots 1..N-1).
module hwsw_frame_commit
   import hwsw_pkg::*;
#(
   parameter int NUM_OBJ  = 16,
   parameter int SCREEN_H = 480
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 to_hw_sig,
   input  logic [NUM_OBJ*32-1:0]      to_hw_data,
   input  logic                       frame_start,
   output logic [1:0]                 to_sw_sig,
   output logic [NUM_OBJ*COORD_W-1:0] obj_x,
   output logic [NUM_OBJ*COORD_W-1:0] obj_y,
   output logic [NUM_OBJ*3-1:0]       obj_state,
   output logic [NUM_OBJ*3-1:0]       obj_type,
   output logic                       frame_committed,
   output logic                       proto_err
);

   hwsw_fsm_e   state_q, state_d;
   hwsw_phase_e cur_phase_q, cur_phase_d;
   logic [1:0]  to_sw_sig_q, to_sw_sig_d;
   logic [2:0]  seen_mask_q, seen_mask_d;
   logic        frame_committed_q, frame_committed_d;
   logic        proto_err_q, proto_err_d;

   logic        commit;
   hwsw_phase_e wr_phase;
   obj_rec_t    slot_active [NUM_OBJ];

   // Handshake next-state, seen_mask bookkeeping and commit decision
   always_comb begin
      state_d           = state_q;
      cur_phase_d       = cur_phase_q;
      to_sw_sig_d       = to_sw_sig_q;
      proto_err_d       = proto_err_q;

      commit            = frame_start && (seen_mask_q == 3'b111);
      frame_committed_d = commit;
      wr_phase          = (state_q == S_CAPTURE) ? cur_phase_q : IDLE_P;

      // A commit consumes the mask; a same-cycle capture then starts the next one
      seen_mask_d       = commit ? 3'b000 : seen_mask_q;

      case (state_q)
         S_IDLE: begin
            to_sw_sig_d = 2'd0;
            if (to_hw_sig != 2'd0) begin
               cur_phase_d = hwsw_phase_e'(to_hw_sig);
               state_d     = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            seen_mask_d = seen_mask_d | phase_bit(cur_phase_q);
            to_sw_sig_d = cur_phase_q;
            state_d     = S_ACK;
         end
         S_ACK: begin
            if (to_hw_sig == 2'd0) begin
               to_sw_sig_d = 2'd0;
               state_d     = S_IDLE;
            end else if (to_hw_sig != cur_phase_q) begin
               // CPU switched phase without releasing; flag it and hold the ack
               proto_err_d = 1'b1;
            end
         end
         default: begin
            to_sw_sig_d = 2'd0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // Controller state and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q           <= S_IDLE;
         cur_phase_q       <= IDLE_P;
         to_sw_sig_q       <= 2'd0;
         seen_mask_q       <= 3'b000;
         frame_committed_q <= 1'b0;
         proto_err_q       <= 1'b0;
      end else begin
         state_q           <= state_d;
         cur_phase_q       <= cur_phase_d;
         to_sw_sig_q       <= to_sw_sig_d;
         seen_mask_q       <= seen_mask_d;
         frame_committed_q <= frame_committed_d;
         proto_err_q       <= proto_err_d;
      end
   end

   assign to_sw_sig       = to_sw_sig_q;
   assign frame_committed = frame_committed_q;
   assign proto_err       = proto_err_q;

   for (genvar i = 0; i < NUM_OBJ; i++) begin : g_slot
      hwsw_obj_slot #(
         .SLOT_IDX (i),
         .SCREEN_H (SCREEN_H)
      ) u_slot (
         .clk      (clk),
         .reset    (reset),
         .wr_phase (wr_phase),
         .wr_data  (to_hw_data[32*i +: 32]),
         .commit   (commit),
         .active   (slot_active[i])
      );

      assign obj_x[COORD_W*i +: COORD_W] = slot_active[i].x;
      assign obj_y[COORD_W*i +: COORD_W] = slot_active[i].y;
      assign obj_state[3*i +: 3]         = slot_active[i].state;
      assign obj_type[3*i +: 3]          = slot_active[i].typ;
   end

endmodule

// File: tb/tb_hwsw_frame_commit.sv
// tb_hwsw_frame_commit: randomized scoreboard bench for hwsw_frame_commit.
// A transaction-level model (shadow/active arrays plus three "seen" flags)
// predicts acks and commits; a monitor pops expectations as the DUT presents
// acknowledges and commit pulses.
module tb_hwsw_frame_commit;

   localparam int NUM_OBJ  = 16;
   localparam int SCREEN_H = 480;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [1:0]            to_hw_sig;
   logic [NUM_OBJ*32-1:0] to_hw_data;
   logic                  frame_start;
   logic [1:0]            to_sw_sig;
   logic [NUM_OBJ*10-1:0] obj_x, obj_y;
   logic [NUM_OBJ*3-1:0]  obj_state, obj_type;
   logic                  frame_committed, proto_err;

   always #5 clk = ~clk;

   hwsw_frame_commit #(.NUM_OBJ(NUM_OBJ), .SCREEN_H(SCREEN_H)) dut (
      .clk             (clk),
      .reset           (reset),
      .to_hw_sig       (to_hw_sig),
      .to_hw_data      (to_hw_data),
      .frame_start     (frame_start),
      .to_sw_sig       (to_sw_sig),
      .obj_x           (obj_x),
      .obj_y           (obj_y),
      .obj_state       (obj_state),
      .obj_type        (obj_type),
      .frame_committed (frame_committed),
      .proto_err       (proto_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [NUM_OBJ*10-1:0] x;
      logic [NUM_OBJ*10-1:0] y;
      logic [NUM_OBJ*3-1:0]  st;
      logic [NUM_OBJ*3-1:0]  ty;
   } bank_t;

   int unsigned sh_x [NUM_OBJ], sh_y [NUM_OBJ], sh_st [NUM_OBJ], sh_ty [NUM_OBJ];
   int unsigned ac_x [NUM_OBJ], ac_y [NUM_OBJ], ac_st [NUM_OBJ], ac_ty [NUM_OBJ];
   bit          seen_x, seen_y, seen_st;
   logic [31:0] cur_data [NUM_OBJ];

   logic [1:0]  ack_q [$];
   bank_t       commit_q [$];
   logic [1:0]  mon_prev;

   function automatic int unsigned yproc(input int slot, input int unsigned raw);
      int unsigned r;
      r = raw;
`ifdef HWSW_YFLIP_EN
      if (slot != 0) r = (SCREEN_H + 1024 - raw) % 1024;
`endif
      return r;
   endfunction

   function automatic bank_t model_active();
      bank_t b;
      for (int i = 0; i < NUM_OBJ; i++) begin
         b.x[10*i +: 10] = 10'(ac_x[i]);
         b.y[10*i +: 10] = 10'(ac_y[i]);
         b.st[3*i +: 3]  = 3'(ac_st[i]);
         b.ty[3*i +: 3]  = 3'(ac_ty[i]);
      end
      return b;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_OBJ; i++) begin
         sh_x[i] = 0; sh_y[i] = 0; sh_st[i] = 0; sh_ty[i] = 0;
         ac_x[i] = 0; ac_y[i] = 0; ac_st[i] = 0; ac_ty[i] = 0;
      end
      seen_x = 0; seen_y = 0; seen_st = 0;
   endtask

   task automatic model_write(input int ph);
      for (int i = 0; i < NUM_OBJ; i++) begin
         case (ph)
            1: sh_x[i] = cur_data[i] % 1024;
            2: sh_y[i] = yproc(i, cur_data[i] % 1024);
            3: begin
               sh_st[i] = cur_data[i] % 8;
               sh_ty[i] = (cur_data[i] / 8) % 8;
            end
            default: ;
         endcase
      end
      if (ph == 1) seen_x = 1;
      if (ph == 2) seen_y = 1;
      if (ph == 3) seen_st = 1;
   endtask

   // Returns 1 when this frame boundary commits
   task automatic model_frame(output bit did);
      did = seen_x && seen_y && seen_st;
      if (did) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_st[i] = sh_st[i]; ac_ty[i] = sh_ty[i];
         end
         seen_x = 0; seen_y = 0; seen_st = 0;
         commit_q.push_back(model_active());
      end
   endtask

   // ---------------- driver ----------------
   task automatic rand_data();
      for (int i = 0; i < NUM_OBJ; i++) cur_data[i] = $urandom;
   endtask

   task automatic drive_data();
      for (int i = 0; i < NUM_OBJ; i++) to_hw_data[32*i +: 32] = cur_data[i];
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Full handshake, entered and left on a negedge; optional frame_start
   // coincident with the CAPTURE cycle.
   task automatic handshake(input int ph, input bit fs_on_capture);
      bit did;
      did = 0;
      ack_q.push_back(2'(ph));
      drive_data();
      to_hw_sig = 2'(ph);
      cycle();
      check("ack_zero_in_capture", to_sw_sig, 0);
      if (fs_on_capture) begin
         frame_start = 1'b1;
         model_frame(did);
      end
      model_write(ph);
      cycle();
      frame_start = 1'b0;
      check("ack_latency", to_sw_sig, ph);
      check("capture_commit_pulse", frame_committed, did);
      to_hw_sig = 2'd0;
      cycle();
      check("ack_release", to_sw_sig, 0);
   endtask

   task automatic frame();
      bit    did;
      bank_t e;
      frame_start = 1'b1;
      model_frame(did);
      cycle();
      frame_start = 1'b0;
      e = model_active();
      check("frame_pulse", frame_committed, did);
      check("active_x", obj_x, e.x);
      check("active_y", obj_y, e.y);
      check("active_state", obj_state, e.st);
      check("active_type", obj_type, e.ty);
   endtask

   // ---------------- monitor ----------------
   initial begin
      mon_prev = 2'd0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_prev = 2'd0;
         end else begin
            if (to_sw_sig != 2'd0 && mon_prev == 2'd0) begin
               if (ack_q.size() == 0) check("ack_unexpected", to_sw_sig, 0);
               else check("ack_phase", to_sw_sig, ack_q.pop_front());
            end
            mon_prev = to_sw_sig;
            if (frame_committed) begin
               if (commit_q.size() == 0) begin
                  check("commit_unexpected", frame_committed, 0);
               end else begin
                  bank_t e;
                  e = commit_q.pop_front();
                  check("commit_x", obj_x, e.x);
                  check("commit_y", obj_y, e.y);
                  check("commit_state", obj_state, e.st);
                  check("commit_type", obj_type, e.ty);
               end
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [9:0] exp_y3;
      reset       = 1'b1;
      to_hw_sig   = 2'd0;
      to_hw_data  = '0;
      frame_start = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      cycle();

      // reset state
      check("rst_to_sw_sig", to_sw_sig, 0);
      check("rst_committed", frame_committed, 0);
      check("rst_proto_err", proto_err, 0);
      check("rst_obj_x", obj_x, 0);
      check("rst_obj_y", obj_y, 0);
      check("rst_obj_state", {obj_state, obj_type}, 0);

      // X and Y only: frame boundary must not commit
      rand_data(); handshake(1, 0);
      rand_data(); handshake(2, 0);
      frame();
      check("incomplete_keeps_zero", obj_x, 0);
      rand_data(); handshake(3, 0);
      frame();

      // Directed slot 3 values; upper port bits are random noise
      rand_data(); cur_data[3] = ($urandom & 32'hFFFF_FC00) | 32'd100;
      handshake(1, 0);
      rand_data(); cur_data[3] = ($urandom & 32'hFFFF_FC00) | 32'd40;
      cur_data[0] = ($urandom & 32'hFFFF_FC00) | 32'd40;
      handshake(2, 0);
      rand_data(); cur_data[3] = ($urandom & 32'hFFFF_FFC0) | 32'h1A;
      handshake(3, 0);
      frame();
`ifdef HWSW_YFLIP_EN
      exp_y3 = 10'd440;
`else
      exp_y3 = 10'd40;
`endif
      check("slot3_x", obj_x[30 +: 10], 100);
      check("slot3_y", obj_y[30 +: 10], exp_y3);
      check("slot3_state", obj_state[9 +: 3], 2);
      check("slot3_type", obj_type[9 +: 3], 3);
      check("slot0_y_raw", obj_y[0 +: 10], 40);

      // Y above SCREEN_H into slot 2 (wraps when flipped)
      rand_data(); handshake(1, 0);
      rand_data(); cur_data[2] = 32'd500; handshake(2, 0);
      rand_data(); handshake(3, 0);
      frame();
`ifdef HWSW_YFLIP_EN
      check("slot2_y_wrap", obj_y[20 +: 10], 1004);
`else
      check("slot2_y_raw", obj_y[20 +: 10], 500);
`endif

      // Commit coincident with CAPTURE of a second X; X bit must carry over
      rand_data(); handshake(1, 0);
      rand_data(); handshake(2, 0);
      rand_data(); handshake(3, 0);
      rand_data(); handshake(1, 1);
      rand_data(); handshake(2, 0);
      rand_data(); handshake(3, 0);
      frame();

      // Protocol violation: code 2 while acknowledging phase 1
      check("proto_err_before", proto_err, 0);
      rand_data();
      ack_q.push_back(2'd1);
      drive_data();
      to_hw_sig = 2'd1;
      model_write(1);
      cycle();
      cycle();
      check("proto_ack_x", to_sw_sig, 1);
      rand_data(); drive_data();
      to_hw_sig = 2'd2;
      cycle();
      cycle();
      check("proto_err_set", proto_err, 1);
      check("proto_ack_held", to_sw_sig, 1);
      to_hw_sig = 2'd0;
      cycle();
      check("proto_release", to_sw_sig, 0);
      frame();   // Y shadow from before must be intact
      rand_data(); handshake(2, 0);
      check("proto_err_sticky", proto_err, 1);

      // Randomized traffic
      for (int n = 0; n < 30; n++) begin
         rand_data();
         handshake($urandom_range(1, 3), $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) == 0) frame();
      end

      // Reset during CAPTURE of the last phase of a complete set
      rand_data(); handshake(1, 0);
      rand_data(); handshake(2, 0);
      rand_data(); drive_data();
      to_hw_sig = 2'd3;
      cycle();
      reset = 1'b1;
      to_hw_sig = 2'd0;
      model_reset();
      cycle();
      check("rst2_to_sw_sig", to_sw_sig, 0);
      check("rst2_proto_err", proto_err, 0);
      check("rst2_committed", frame_committed, 0);
      check("rst2_obj", {obj_x, obj_y}, 0);
      reset = 1'b0;
      cycle();
      frame();
      check("rst2_no_commit_state", {obj_state, obj_type}, 0);

      // Normal operation resumes after reset
      rand_data(); handshake(3, 0);
      rand_data(); handshake(1, 0);
      rand_data(); handshake(2, 0);
      frame();

      cycle();
      check("ack_queue_drained", ack_q.size(), 0);
      check("commit_queue_drained", commit_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time bound so the run always ends
   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
